// File: rtl/knight_rd_pkg.sv
// knight_rd_pkg: register indices, response codes and read FSM states shared by the knight_rd slave.
package knight_rd_pkg;
   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_PRESCALE = 2'd1;
   localparam logic [1:0] REG_SCRATCH0 = 2'd2;
   localparam logic [1:0] REG_SCRATCH1 = 2'd3;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/knight_rd_scanner.sv
// knight_rd_scanner: prescaled one-hot LED bouncer that reverses at either end of the bar.
module knight_rd_scanner #(
   parameter int C_NUM_LEDS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [31:0]           prescale,
   output logic [C_NUM_LEDS-1:0] leds,
   output logic                  scan_dir
);
   logic [31:0] cnt;
   logic [C_NUM_LEDS-1:0] nxt;
   logic tick;
   assign tick = cnt >= prescale;
   assign nxt = scan_dir ? leds >> 1 : leds << 1;
   // direction flips on arrival at an end, so the following tick already moves back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         leds     <= C_NUM_LEDS'(1);
         scan_dir <= 1'b0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + 32'd1;
         if (tick) begin
            leds     <= nxt;
            scan_dir <= scan_dir ? ~nxt[0] : nxt[C_NUM_LEDS-1];
         end
      end
   end
endmodule

// File: rtl/knight_rd_axil_slave.sv
// knight_rd_axil_slave: AXI4-Lite slave with four registers driving a knight_rd_scanner.
// Define KNIGHT_RD_AXIL_WSTRB_EN to honour WSTRB byte lanes; otherwise every write is full-word.
module knight_rd_axil_slave
   import knight_rd_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int C_NUM_LEDS         = 8
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [C_NUM_LEDS-1:0]         leds,
   output logic                          scan_dir
);
   logic ready_en, aw_held, w_held, aw_hs, w_hs, ar_hs, commit;
   logic [1:0] aw_idx, widx;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data, wd, mask;
   logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
   logic [3:0] w_strb, ws, be;
   r_state_t r_state;
   logic unused_ok;
   assign S_AXI_AWREADY = ready_en & ~aw_held & ~S_AXI_BVALID;
   assign S_AXI_WREADY  = ready_en & ~w_held & ~S_AXI_BVALID;
   assign S_AXI_ARREADY = ready_en & (r_state == R_IDLE);
   assign S_AXI_BRESP   = AXI_RESP_OKAY;
   assign S_AXI_RRESP   = AXI_RESP_OKAY;
   assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign commit = (aw_held | aw_hs) & (w_held | w_hs);
   assign widx   = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx;
   assign wd     = w_hs ? S_AXI_WDATA : w_data;
   assign ws     = w_hs ? S_AXI_WSTRB : w_strb;
`ifdef KNIGHT_RD_AXIL_WSTRB_EN
   assign be = ws;
`else
   assign be = 4'hF;
`endif
   assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], ws};
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         ready_en     <= 1'b0;
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_idx       <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         S_AXI_BVALID <= 1'b0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         ready_en     <= 1'b1;
         S_AXI_BVALID <= commit | (S_AXI_BVALID & ~S_AXI_BREADY);
         if (commit) begin
            regs[widx] <= (regs[widx] & ~mask) | (wd & mask);
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_held <= 1'b1;
               aw_idx  <= S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
               w_held <= 1'b1;
               w_data <= S_AXI_WDATA;
               w_strb <= S_AXI_WSTRB;
            end
         end
      end
   end
   // read data is sampled before any same-edge write lands, so a racing write is not seen
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state      <= R_IDLE;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
      end else if (r_state == R_IDLE) begin
         if (ar_hs) begin
            S_AXI_RDATA  <= regs[S_AXI_ARADDR[3:2]];
            S_AXI_RVALID <= 1'b1;
            r_state      <= R_DATA;
         end
      end else if (S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
         r_state      <= R_IDLE;
      end
   end
   knight_rd_scanner #(.C_NUM_LEDS(C_NUM_LEDS)) u_scanner (
      .clk      (S_AXI_ACLK),
      .rst_n    (S_AXI_ARESETN),
      .enable   (regs[REG_CTRL][0]),
      .prescale (regs[REG_PRESCALE]),
      .leds     (leds),
      .scan_dir (scan_dir)
   );
endmodule
